output_port: RTL and testbench
==============================

OUTPUT_PORT -- requirements
Module: output_port

Interface
REQ-001 SHALL have parameter VC_NUM, default from noc_params, number of virtual channels on the link.
REQ-002 SHALL have parameter VC_SIZE, default from noc_params, width of a VC index.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port xb_flit_i  input  flit_t  flit from the crossbar (flit_label, vc_id, data).
REQ-006 SHALL have port xb_valid_i  input  1  xb_flit_i carries a flit this cycle.
REQ-007 SHALL have port on_off_i  input  VC_NUM  per-VC on/off flow control from the downstream input port; 1 = sending permitted.
REQ-008 SHALL have port is_allocatable_i  input  VC_NUM  per-VC downstream VC reports it can accept a new packet.
REQ-009 SHALL have port data_o  output  flit_t  registered flit driven onto the link.
REQ-010 SHALL have port valid_flit_o  output  1  data_o is valid this cycle.
REQ-011 SHALL have port vc_free_o  output  VC_NUM  per-VC downstream VC is available to the VC allocator.
REQ-012 SHALL have port vc_ready_o  output  VC_NUM  per-VC switch allocator may send a flit on this VC.
REQ-013 SHALL have port error_o  output  VC_NUM  per-VC one-cycle protocol-violation pulse.

Function
REQ-014 SHALL keep one 2-state FSM per VC: IDLE (no packet owns the downstream VC) and BUSY (packet in transmission).
REQ-015 A flit is "accepted" when xb_valid_i=1, on_off_i[vc_id]=1 and its label is legal for the VC state (REQ-016..018).
REQ-016 IDLE: HEAD accepted -> BUSY; HEADTAIL accepted -> stays IDLE; BODY or TAIL -> illegal.
REQ-017 BUSY: BODY accepted -> stays BUSY; TAIL accepted -> IDLE; HEAD or HEADTAIL -> illegal.
REQ-018 HEAD/HEADTAIL SHALL also require is_allocatable_i[vc_id]=1 in the same cycle; otherwise illegal.
REQ-019 Accepted flit SHALL appear unchanged on data_o with valid_flit_o=1 exactly one cycle later (latency 1).
REQ-020 Cycle with no accepted flit SHALL drive valid_flit_o=0 next cycle; data_o holds its last value.
REQ-021 Illegal flit, or flit with on_off_i[vc_id]=0, SHALL be dropped (not forwarded, no state change) and pulse error_o[vc_id]=1 for exactly the next cycle.
REQ-022 error_o bits other than the offending vc_id SHALL be 0; with no violation, all error_o bits SHALL be 0.
REQ-023 vc_free_o[v] SHALL be combinational: state[v]==IDLE and is_allocatable_i[v].
REQ-024 vc_ready_o[v] SHALL be combinational: on_off_i[v].
REQ-025 TAIL accepted in cycle t SHALL make vc_free_o[v] eligible from cycle t+1; never in cycle t.
REQ-026 HEAD accepted in cycle t SHALL drop vc_free_o[v] from cycle t+1.
REQ-027 on_off_i[v] falling mid-packet SHALL leave state[v] BUSY; transmission resumes when on_off_i[v] returns to 1.
REQ-028 At most one flit per cycle SHALL be processed; VC states are independent.

Reset
REQ-029 rst=1 at a clock edge SHALL force every VC to IDLE, valid_flit_o=0, error_o=0, data_o=0.
REQ-030 Reset SHALL override a flit presented in the same cycle; that flit is neither forwarded nor flagged.
REQ-031 Reset mid-packet SHALL abandon the packet; a subsequent BODY/TAIL on that VC is illegal per REQ-016.

Verification
REQ-032 After reset with is_allocatable_i=all 1, send HEAD, BODY, TAIL on vc 1 with on_off_i=all 1 -> three consecutive valid_flit_o=1 cycles, each one cycle after input; vc_free_o[1]=0 from cycle after HEAD until cycle after TAIL, then 1.
REQ-033 Send HEADTAIL on vc 0 -> forwarded next cycle, vc_free_o[0] stays 1, error_o=0.
REQ-034 Send BODY on IDLE vc 2 -> valid_flit_o=0 next cycle, error_o=4'b0100 (VC_NUM=4) for one cycle, state unchanged.
REQ-035 Mid-packet on vc 3, drop on_off_i[3] to 0 and send BODY -> dropped, error_o[3] pulses; raise on_off_i[3], send BODY, TAIL -> both forwarded, vc 3 returns IDLE.
REQ-036 Assert rst while vc 1 is BUSY and a flit is valid -> next cycle valid_flit_o=0, data_o=0, vc_free_o[1]=is_allocatable_i[1], error_o=0.
REQ-037 HEAD on vc 0 with is_allocatable_i[0]=0 -> dropped, error_o[0] pulses, vc 0 stays IDLE.

Source files
------------

// File: rtl/output_port.sv
// Link-side output port: per-VC packet tracking, on/off flow control
// and a one-cycle registered flit stage toward the downstream router.
package noc_params;
    localparam int VC_NUM = 4;
    localparam int VC_SIZE = 2;
    localparam int DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        HEAD     = 2'b00,
        BODY     = 2'b01,
        TAIL     = 2'b10,
        HEADTAIL = 2'b11
    } flit_label_t;

    typedef struct packed {
        flit_label_t flit_label;
        logic [VC_SIZE-1:0] vc_id;
        logic [DATA_WIDTH-1:0] data;
    } flit_t;
endpackage

module output_port
    import noc_params::*;
#(
    parameter int VC_NUM = noc_params::VC_NUM,
    parameter int VC_SIZE = noc_params::VC_SIZE
) (
    input  logic              clk,
    input  logic              rst,
    input  flit_t             xb_flit_i,
    input  logic              xb_valid_i,
    input  logic [VC_NUM-1:0] on_off_i,
    input  logic [VC_NUM-1:0] is_allocatable_i,
    output flit_t             data_o,
    output logic              valid_flit_o,
    output logic [VC_NUM-1:0] vc_free_o,
    output logic [VC_NUM-1:0] vc_ready_o,
    output logic [VC_NUM-1:0] error_o
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } vc_state_t;

    vc_state_t state [VC_NUM];

    logic [VC_SIZE-1:0] vc;
    vc_state_t cur_state;
    vc_state_t next_state;
    logic legal;
    logic accept;
    logic violate;

    assign vc = xb_flit_i.vc_id;

    always_comb begin
        cur_state = state[vc];
        next_state = cur_state;
        legal = 1'b0;
        unique case (xb_flit_i.flit_label)
            HEAD: begin
                legal = (cur_state == IDLE) && is_allocatable_i[vc];
                next_state = BUSY;
            end
            HEADTAIL: begin
                legal = (cur_state == IDLE) && is_allocatable_i[vc];
                next_state = IDLE;
            end
            BODY: begin
                legal = (cur_state == BUSY);
                next_state = BUSY;
            end
            TAIL: begin
                legal = (cur_state == BUSY);
                next_state = IDLE;
            end
        endcase
        accept = xb_valid_i && on_off_i[vc] && legal;
        violate = xb_valid_i && !accept;
    end

    always_comb begin
        for (int v = 0; v < VC_NUM; v++) begin
            vc_free_o[v] = (state[v] == IDLE) && is_allocatable_i[v];
        end
    end

    assign vc_ready_o = on_off_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int v = 0; v < VC_NUM; v++) begin
                state[v] <= IDLE;
            end
            valid_flit_o <= 1'b0;
            error_o <= '0;
            data_o <= '0;
        end else begin
            valid_flit_o <= accept;
            error_o <= '0;
            if (accept) begin
                data_o <= xb_flit_i;
                state[vc] <= next_state;
            end
            // Dropped flits leave the VC state untouched
            if (violate) begin
                error_o[vc] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_output_port.sv
// Directed vector bench for output_port.
module tb_output_port;
    import noc_params::*;

    logic clk = 1'b0;
    logic rst;
    flit_t xb_flit_i;
    logic xb_valid_i;
    logic [3:0] on_off_i;
    logic [3:0] is_allocatable_i;
    flit_t data_o;
    logic valid_flit_o;
    logic [3:0] vc_free_o;
    logic [3:0] vc_ready_o;
    logic [3:0] error_o;

    int n_vec = 0;
    int n_bad = 0;

    output_port dut (
        .clk(clk),
        .rst(rst),
        .xb_flit_i(xb_flit_i),
        .xb_valid_i(xb_valid_i),
        .on_off_i(on_off_i),
        .is_allocatable_i(is_allocatable_i),
        .data_o(data_o),
        .valid_flit_o(valid_flit_o),
        .vc_free_o(vc_free_o),
        .vc_ready_o(vc_ready_o),
        .error_o(error_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic rst;
        logic valid;
        flit_t f;
        logic [3:0] on;
        logic [3:0] al;
        logic [3:0] epre;
        logic ev;
        flit_t ed;
        logic [3:0] ee;
        logic [3:0] efree;
    } vec_t;

    vec_t tbl[$];

    function automatic flit_t mk(flit_label_t l, int v, logic [15:0] d);
        flit_t f;
        f.flit_label = l;
        f.vc_id = v[1:0];
        f.data = d;
        return f;
    endfunction

    function automatic vec_t vv(logic r, logic va, flit_t f,
                                logic [3:0] on, logic [3:0] al,
                                logic [3:0] epre, logic ev, flit_t ed,
                                logic [3:0] ee, logic [3:0] efree);
        vec_t x;
        x.rst = r; x.valid = va; x.f = f; x.on = on; x.al = al;
        x.epre = epre; x.ev = ev; x.ed = ed; x.ee = ee; x.efree = efree;
        return x;
    endfunction

    task automatic apply(input vec_t x, input string name);
        @(negedge clk);
        rst = x.rst;
        xb_valid_i = x.valid;
        xb_flit_i = x.f;
        on_off_i = x.on;
        is_allocatable_i = x.al;
        #1;
        n_vec++;
        if (vc_free_o !== x.epre) begin
            n_bad++;
            $display("FAIL %s pre vc_free got %b want %b", name, vc_free_o, x.epre);
        end
        if (vc_ready_o !== x.on) begin
            n_bad++;
            $display("FAIL %s vc_ready got %b want %b", name, vc_ready_o, x.on);
        end
        @(posedge clk);
        #1;
        if (valid_flit_o !== x.ev) begin
            n_bad++;
            $display("FAIL %s valid got %b want %b", name, valid_flit_o, x.ev);
        end
        if (data_o !== x.ed) begin
            n_bad++;
            $display("FAIL %s data got %h want %h", name, data_o, x.ed);
        end
        if (error_o !== x.ee) begin
            n_bad++;
            $display("FAIL %s error got %b want %b", name, error_o, x.ee);
        end
        if (vc_free_o !== x.efree) begin
            n_bad++;
            $display("FAIL %s vc_free got %b want %b", name, vc_free_o, x.efree);
        end
    endtask

    initial begin
        flit_t z;
        flit_t ht0;
        flit_t h3;
        flit_t h2;
        z = '0;
        ht0 = mk(HEADTAIL, 0, 16'h4444);
        h3 = mk(HEAD, 3, 16'h7777);
        h2 = mk(HEAD, 2, 16'h1616);

        // reset state
        tbl.push_back(vv(1, 0, z, 4'hF, 4'hF, 4'hF, 0, z, 4'h0, 4'hF));
        // HEAD/BODY/TAIL on vc 1
        tbl.push_back(vv(0, 1, mk(HEAD, 1, 16'h1111), 4'hF, 4'hF,
                         4'hF, 1, mk(HEAD, 1, 16'h1111), 4'h0, 4'hD));
        tbl.push_back(vv(0, 1, mk(BODY, 1, 16'h2222), 4'hF, 4'hF,
                         4'hD, 1, mk(BODY, 1, 16'h2222), 4'h0, 4'hD));
        tbl.push_back(vv(0, 1, mk(TAIL, 1, 16'h3333), 4'hF, 4'hF,
                         4'hD, 1, mk(TAIL, 1, 16'h3333), 4'h0, 4'hF));
        // HEADTAIL on vc 0
        tbl.push_back(vv(0, 1, ht0, 4'hF, 4'hF, 4'hF, 1, ht0, 4'h0, 4'hF));
        // BODY on idle vc 2, then quiet cycle
        tbl.push_back(vv(0, 1, mk(BODY, 2, 16'h5555), 4'hF, 4'hF,
                         4'hF, 0, ht0, 4'h4, 4'hF));
        tbl.push_back(vv(0, 0, z, 4'hF, 4'hF, 4'hF, 0, ht0, 4'h0, 4'hF));
        // vc 3 with on/off stall
        tbl.push_back(vv(0, 1, h3, 4'hF, 4'hF, 4'hF, 1, h3, 4'h0, 4'h7));
        tbl.push_back(vv(0, 1, mk(BODY, 3, 16'h8888), 4'h7, 4'hF,
                         4'h7, 0, h3, 4'h8, 4'h7));
        tbl.push_back(vv(0, 1, mk(BODY, 3, 16'h9999), 4'hF, 4'hF,
                         4'h7, 1, mk(BODY, 3, 16'h9999), 4'h0, 4'h7));
        tbl.push_back(vv(0, 1, mk(TAIL, 3, 16'hAAAA), 4'hF, 4'hF,
                         4'h7, 1, mk(TAIL, 3, 16'hAAAA), 4'h0, 4'hF));
        // reset mid-packet on vc 1 with a flit present
        tbl.push_back(vv(0, 1, mk(HEAD, 1, 16'hBBBB), 4'hF, 4'hF,
                         4'hF, 1, mk(HEAD, 1, 16'hBBBB), 4'h0, 4'hD));
        tbl.push_back(vv(1, 1, mk(BODY, 1, 16'hCCCC), 4'hF, 4'hF,
                         4'hD, 0, z, 4'h0, 4'hF));
        tbl.push_back(vv(0, 1, mk(TAIL, 1, 16'hDDDD), 4'hF, 4'hF,
                         4'hF, 0, z, 4'h2, 4'hF));
        // HEAD on vc 0 while not allocatable
        tbl.push_back(vv(0, 1, mk(HEAD, 0, 16'hEEEE), 4'hF, 4'hE,
                         4'hE, 0, z, 4'h1, 4'hE));
        tbl.push_back(vv(0, 0, z, 4'hF, 4'hF, 4'hF, 0, z, 4'h0, 4'hF));
        // vc 2 busy: second HEAD illegal, vc 0 independent
        tbl.push_back(vv(0, 1, h2, 4'hF, 4'hF, 4'hF, 1, h2, 4'h0, 4'hB));
        tbl.push_back(vv(0, 1, mk(HEAD, 2, 16'h1717), 4'hF, 4'hF,
                         4'hB, 0, h2, 4'h4, 4'hB));
        tbl.push_back(vv(0, 1, mk(HEADTAIL, 0, 16'h1818), 4'hF, 4'hF,
                         4'hB, 1, mk(HEADTAIL, 0, 16'h1818), 4'h0, 4'hB));
        tbl.push_back(vv(0, 1, mk(TAIL, 2, 16'h1919), 4'hF, 4'hF,
                         4'hB, 1, mk(TAIL, 2, 16'h1919), 4'h0, 4'hF));

        rst = 1'b1;
        xb_valid_i = 1'b0;
        xb_flit_i = '0;
        on_off_i = 4'hF;
        is_allocatable_i = 4'hF;
        repeat (2) @(posedge clk);

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // back-to-back violations on different VCs: each pulse lasts one cycle
        apply(vv(0, 1, mk(BODY, 0, 16'h0A0A), 4'hF, 4'hF, 4'hF, 0,
                 mk(TAIL, 2, 16'h1919), 4'h1, 4'hF), "err_seq0");
        apply(vv(0, 1, mk(TAIL, 1, 16'h0B0B), 4'hF, 4'hF, 4'hF, 0,
                 mk(TAIL, 2, 16'h1919), 4'h2, 4'hF), "err_seq1");
        apply(vv(0, 0, z, 4'hF, 4'hF, 4'hF, 0,
                 mk(TAIL, 2, 16'h1919), 4'h0, 4'hF), "err_seq2");

        // stalled legal HEAD is dropped and does not claim the VC
        apply(vv(0, 1, mk(HEAD, 1, 16'h0C0C), 4'hD, 4'hF, 4'hF, 0,
                 mk(TAIL, 2, 16'h1919), 4'h2, 4'hF), "stall_head");
        apply(vv(0, 1, mk(HEAD, 1, 16'h0D0D), 4'hF, 4'hF, 4'hF, 1,
                 mk(HEAD, 1, 16'h0D0D), 4'h0, 4'hD), "retry_head");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
